// File: rtl/mem_arbiter.sv
// Two-port line arbiter: I-cache and D-cache share one line memory.
// D has priority; a saturating counter forces an I grant after STARVE_LIMIT D wins.
module mem_arbiter #(
  parameter int ADDR_W       = 28,
  parameter int DATA_W       = 128,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_read,
  input  logic              i_write,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ready,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              grant_d
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D, RELEASE} state_t;

  state_t            state, state_nx;
  logic [CNT_W-1:0]  starve_cnt, starve_nx;
  logic              mem_read_nx, mem_write_nx;
  logic [ADDR_W-1:0] mem_addr_nx;
  logic [DATA_W-1:0] mem_wdata_nx;
  logic              req_i, req_d, pick_d;

  assign req_i  = i_read | i_write;
  assign req_d  = d_read | d_write;
  assign pick_d = req_d & (~req_i | (starve_cnt < LIMIT));

  // Read data is broadcast; only the ready of the granted side qualifies it.
  assign i_rdata = mem_rdata;
  assign d_rdata = mem_rdata;
  assign i_ready = (state == SERVE_I) & mem_ready;
  assign d_ready = (state == SERVE_D) & mem_ready;

  always_comb begin
    state_nx     = state;
    starve_nx    = starve_cnt;
    mem_read_nx  = mem_read;
    mem_write_nx = mem_write;
    mem_addr_nx  = mem_addr;
    mem_wdata_nx = mem_wdata;
    case (state)
      IDLE: begin
        if (req_i | req_d) begin
          if (pick_d) begin
            state_nx     = SERVE_D;
            mem_addr_nx  = d_addr;
            mem_wdata_nx = d_wdata;
            mem_write_nx = d_write;
            mem_read_nx  = d_read & ~d_write;
            if (!req_i)                  starve_nx = '0;
            else if (starve_cnt < LIMIT) starve_nx = starve_cnt + 1'b1;
          end else begin
            state_nx     = SERVE_I;
            mem_addr_nx  = i_addr;
            mem_wdata_nx = i_wdata;
            mem_write_nx = i_write;
            mem_read_nx  = i_read & ~i_write;
            starve_nx    = '0;
          end
        end
      end
      SERVE_I, SERVE_D: begin
        if (mem_ready) begin
          state_nx     = RELEASE;
          mem_read_nx  = 1'b0;
          mem_write_nx = 1'b0;
        end
      end
      // One dead cycle so a cache can drop the request it saw complete.
      RELEASE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      starve_cnt <= '0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      grant_d    <= 1'b0;
    end else begin
      state      <= state_nx;
      starve_cnt <= starve_nx;
      mem_read   <= mem_read_nx;
      mem_write  <= mem_write_nx;
      mem_addr   <= mem_addr_nx;
      mem_wdata  <= mem_wdata_nx;
      grant_d    <= (state_nx == SERVE_D);
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table, hand-written corner sequences,
// then randomized traffic against a transaction-level reference model.
module tb_mem_arbiter;
  localparam int AW  = 28;
  localparam int DW  = 128;
  localparam int LIM = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          i_read, i_write, d_read, d_write, mem_ready;
  logic [AW-1:0] i_addr, d_addr;
  logic [DW-1:0] i_wdata, d_wdata, mem_rdata;
  logic [DW-1:0] i_rdata, d_rdata, mem_wdata;
  logic          i_ready, d_ready, mem_read, mem_write, grant_d;
  logic [AW-1:0] mem_addr;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_read(i_read), .i_write(i_write), .i_addr(i_addr), .i_wdata(i_wdata),
    .i_rdata(i_rdata), .i_ready(i_ready),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .grant_d(grant_d)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  localparam logic [DW-1:0] P0    = '0;
  localparam logic [DW-1:0] P1    = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  localparam logic [DW-1:0] PA5   = {16{8'hA5}};
  localparam logic [DW-1:0] P5A   = {16{8'h5A}};
  localparam logic [DW-1:0] PBEEF = 128'hDEADBEEF_00000000_00000000_00000001;

  typedef struct {
    logic ir, iw, dr, dw;
    logic [AW-1:0] ia, da;
    logic [DW-1:0] iwd, dwd;
    int wt;
    logic e_gd, e_rd, e_wr;
    logic [AW-1:0] e_a;
    logic [DW-1:0] e_wd;
  } vec_t;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  function automatic logic [DW-1:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic drop_all();
    i_read = 0; i_write = 0; d_read = 0; d_write = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b1; #1;
    rst_n = 1'b0;
    drop_all();
    i_addr = '0; d_addr = '0; i_wdata = '0; d_wdata = '0;
    mem_ready = 0; mem_rdata = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // One complete transaction from IDLE: grant edge, wt quiet cycles, ready cycle, release.
  // drop: 0 keep requests, 1 drop all, 2 drop the winner only (after the ready edge).
  task automatic serve(input int wt, input logic ed, input logic [AW-1:0] ea,
                       input logic [DW-1:0] ewd, input logic er, input logic ew,
                       input logic [DW-1:0] rd, input int drop, input string nm);
    step();
    chk({nm, "_grant_d"}, grant_d, ed);
    chk({nm, "_mem_read"}, mem_read, er);
    chk({nm, "_mem_write"}, mem_write, ew);
    chk({nm, "_mem_addr"}, mem_addr, ea);
    chk({nm, "_mem_wdata"}, mem_wdata, ewd);
    for (int k = 0; k < wt; k++) begin
      #1 chk({nm, "_wait_ready"}, {i_ready, d_ready}, 2'b00);
      step();
      chk({nm, "_hold_addr"}, mem_addr, ea);
      chk({nm, "_hold_strb"}, {mem_read, mem_write}, {er, ew});
    end
    mem_rdata = rd; mem_ready = 1'b1; #1;
    chk({nm, "_ready"}, ed ? d_ready : i_ready, 1'b1);
    chk({nm, "_other_ready"}, ed ? i_ready : d_ready, 1'b0);
    chk({nm, "_rdata"}, ed ? d_rdata : i_rdata, rd);
    step();
    mem_ready = 1'b0;
    if (drop == 1) drop_all();
    else if (drop == 2) begin
      if (ed) begin d_read = 0; d_write = 0; end
      else begin i_read = 0; i_write = 0; end
    end
    #1;
    chk({nm, "_rel_strb"}, {mem_read, mem_write, grant_d}, 3'b000);
    mem_ready = 1'b1; #1;
    chk({nm, "_rel_ready"}, {i_ready, d_ready}, 2'b00);
    step();
    mem_ready = 1'b0;
  endtask

  task automatic random_phase(input int ncyc);
    int starve = 0, free_at = 0, lat = 0;
    bit busy = 0, own_d = 0;
    logic [AW-1:0] ea = '0, pia, pda;
    logic [DW-1:0] ewd = '0, piw, pdw;
    logic er = 0, ew = 0, pir, piwr, pdr, pdwr, pmr, eir, edr;
    for (int e = 0; e < ncyc; e++) begin
      #1;
      eir = busy && !own_d && mem_ready;
      edr = busy && own_d && mem_ready;
      chk("rnd_i_ready", i_ready, eir);
      chk("rnd_d_ready", d_ready, edr);
      if (eir) chk("rnd_i_rdata", i_rdata, mem_rdata);
      if (edr) chk("rnd_d_rdata", d_rdata, mem_rdata);
      pir = i_read; piwr = i_write; pdr = d_read; pdwr = d_write; pmr = mem_ready;
      pia = i_addr; pda = d_addr; piw = i_wdata; pdw = d_wdata;
      step();
      if (busy) begin
        if (pmr) begin busy = 0; free_at = e + 2; end
      end else if (e >= free_at && (pir | piwr | pdr | pdwr)) begin
        own_d = (pdr | pdwr) && (!(pir | piwr) || starve < LIM);
        if (own_d) begin
          starve = (pir | piwr) ? ((starve < LIM) ? starve + 1 : LIM) : 0;
          ea = pda; ewd = pdw; ew = pdwr; er = pdr & ~pdwr;
        end else begin
          starve = 0;
          ea = pia; ewd = piw; ew = piwr; er = pir & ~piwr;
        end
        busy = 1;
        lat = $urandom_range(0, 4);
      end
      chk("rnd_grant_d", grant_d, busy && own_d);
      chk("rnd_mem_read", mem_read, busy && er);
      chk("rnd_mem_write", mem_write, busy && ew);
      if (busy) begin
        chk("rnd_mem_addr", mem_addr, ea);
        chk("rnd_mem_wdata", mem_wdata, ewd);
      end
      // Requesters hold until ready; the served side may scramble or withdraw its request.
      if (eir) begin i_read = 0; i_write = 0; end
      else if (!(i_read | i_write)) begin
        if ($urandom_range(0, 2) == 0) begin
          i_addr = AW'($urandom); i_wdata = rnd128();
          case ($urandom_range(0, 2))
            0: begin i_read = 1; i_write = 0; end
            1: begin i_read = 0; i_write = 1; end
            default: begin i_read = 1; i_write = 1; end
          endcase
        end
      end else if (busy && !own_d && $urandom_range(0, 3) == 0) begin
        i_addr = AW'($urandom); i_wdata = rnd128();
        if ($urandom_range(0, 3) == 0) begin i_read = 0; i_write = 0; end
      end
      if (edr) begin d_read = 0; d_write = 0; end
      else if (!(d_read | d_write)) begin
        if ($urandom_range(0, 1) == 0) begin
          d_addr = AW'($urandom); d_wdata = rnd128();
          case ($urandom_range(0, 2))
            0: begin d_read = 1; d_write = 0; end
            1: begin d_read = 0; d_write = 1; end
            default: begin d_read = 1; d_write = 1; end
          endcase
        end
      end else if (busy && own_d && $urandom_range(0, 3) == 0) begin
        d_addr = AW'($urandom); d_wdata = rnd128();
        if ($urandom_range(0, 3) == 0) begin d_read = 0; d_write = 0; end
      end
      if (busy) begin
        if (lat == 0) mem_ready = 1'b1;
        else begin mem_ready = 1'b0; lat--; end
      end else begin
        mem_ready = ($urandom_range(0, 7) == 0);
      end
      mem_rdata = rnd128();
    end
  endtask

  vec_t vecs[6];

  initial begin
    vecs[0] = '{'1, '0, '0, '0, 28'h4,  28'h0,  P0,  P1,  4, '0, '1, '0, 28'h4,  P0};
    vecs[1] = '{'0, '0, '0, '1, 28'h0,  28'h20, P0,  PA5, 2, '1, '0, '1, 28'h20, PA5};
    vecs[2] = '{'1, '0, '1, '0, 28'h1,  28'h2,  P0,  P1,  3, '1, '1, '0, 28'h2,  P1};
    vecs[3] = '{'0, '0, '1, '1, 28'h0,  28'h33, P0,  P5A, 0, '1, '0, '1, 28'h33, P5A};
    vecs[4] = '{'0, '1, '0, '0, 28'h7,  28'h0,  P5A, P0,  1, '0, '0, '1, 28'h7,  P5A};
    vecs[5] = '{'0, '1, '1, '0, 28'h11, 28'h12, PA5, P1,  2, '1, '1, '0, 28'h12, P1};

    do_reset();
    chk("rst_outputs", {mem_read, mem_write, i_ready, d_ready, grant_d}, 5'b0);
    chk("rst_mem_addr", mem_addr, '0);
    chk("rst_mem_wdata", mem_wdata, '0);

    // Reset asserted in the middle of a D read.
    d_read = 1; d_addr = 28'h10; d_wdata = P1;
    step();
    chk("mid_grant", {grant_d, mem_read, mem_write}, 3'b110);
    chk("mid_addr", mem_addr, 28'h10);
    mem_ready = 1'b1;
    rst_n = 1'b0; #1;
    chk("mid_rst_strb", {mem_read, mem_write, grant_d, i_ready, d_ready}, 5'b0);
    chk("mid_rst_addr", mem_addr, '0);
    chk("mid_rst_wdata", mem_wdata, '0);
    mem_ready = 1'b0; drop_all();
    step(); rst_n = 1'b1;
    step(); step();
    chk("mid_after", {grant_d, mem_read, mem_write}, 3'b000);

    // Spurious mem_ready in IDLE.
    mem_ready = 1'b1; #1;
    chk("spur_idle", {i_ready, d_ready}, 2'b00);
    step();
    chk("spur_idle_strb", {grant_d, mem_read, mem_write}, 3'b000);
    mem_ready = 1'b0;

    for (int v = 0; v < 6; v++) begin
      i_read = vecs[v].ir; i_write = vecs[v].iw; d_read = vecs[v].dr; d_write = vecs[v].dw;
      i_addr = vecs[v].ia; d_addr = vecs[v].da; i_wdata = vecs[v].iwd; d_wdata = vecs[v].dwd;
      serve(vecs[v].wt, vecs[v].e_gd, vecs[v].e_a, vecs[v].e_wd, vecs[v].e_rd, vecs[v].e_wr,
            PBEEF, 1, $sformatf("vec%0d", v));
    end

    // Withdraw and scramble address while being served.
    i_read = 1; i_addr = 28'h55; i_wdata = P1;
    step();
    chk("wd_grant", {grant_d, mem_read}, 2'b01);
    i_read = 0; i_addr = 28'h99; i_wdata = P0;
    step();
    chk("wd_addr", mem_addr, 28'h55);
    chk("wd_wdata", mem_wdata, P1);
    chk("wd_read", mem_read, 1'b1);
    mem_ready = 1'b1; #1;
    chk("wd_ready", {i_ready, d_ready}, 2'b10);
    step(); mem_ready = 1'b0;
    step(); step();
    chk("wd_no_regrant", {grant_d, mem_read, mem_write}, 3'b000);

    // Simultaneous requests: D first, then I, each latency+2 cycles.
    i_read = 1; i_addr = 28'h1; i_wdata = P0;
    d_read = 1; d_addr = 28'h2; d_wdata = P1;
    serve(2, 1'b1, 28'h2, P1, 1'b1, 1'b0, rnd128(), 2, "sim_d");
    serve(2, 1'b0, 28'h1, P0, 1'b1, 1'b0, rnd128(), 1, "sim_i");
    #1 chk("sim_done", {grant_d, mem_read, mem_write}, 3'b000);

    // Starvation guard: four D grants with I waiting, then I, then D again.
    do_reset();
    i_read = 1; i_addr = 28'h40; i_wdata = P5A;
    d_read = 1; d_addr = 28'h41; d_wdata = PA5;
    for (int g = 0; g < 6; g++) begin
      if (g == 4) serve(1, 1'b0, 28'h40, P5A, 1'b1, 1'b0, rnd128(), 0, $sformatf("starve%0d", g));
      else        serve(1, 1'b1, 28'h41, PA5, 1'b1, 1'b0, rnd128(), (g == 5) ? 1 : 0,
                        $sformatf("starve%0d", g));
    end

    do_reset();
    random_phase(4000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Two-port arbiter that lets the instruction cache and the data cache share one slow line-based memory (28-bit line address, 128-bit line). It sits between the cache memory-side ports and the single memory interface. It serialises line read and write transactions, with data-side priority and a starvation guard for the instruction side. It returns mem_ready only to the requester that holds the grant.

Parameters:
ADDR_W, 28, line address width (byte address bits [31:4])
DATA_W, 128, line width in bits
STARVE_LIMIT, 4, consecutive D grants with I pending before I is forced; must be >= 1

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
i_read  input  1  I-cache line read request, held until i_ready
i_write  input  1  I-cache line write request, held until i_ready
i_addr  input  ADDR_W  I-cache line address
i_wdata  input  DATA_W  I-cache write line
i_rdata  output  DATA_W  read line to I-cache
i_ready  output  1  I transaction complete
d_read  input  1  D-cache line read request, held until d_ready
d_write  input  1  D-cache line write request, held until d_ready
d_addr  input  ADDR_W  D-cache line address
d_wdata  input  DATA_W  D-cache write line
d_rdata  output  DATA_W  read line to D-cache
d_ready  output  1  D transaction complete
mem_read  output  1  memory read strobe
mem_write  output  1  memory write strobe
mem_addr  output  ADDR_W  memory line address
mem_wdata  output  DATA_W  memory write line
mem_rdata  input  DATA_W  memory read line
mem_ready  input  1  memory transaction complete, one-cycle pulse
grant_d  output  1  status: 1 while the D transaction is in SERVE_D

Behaviour:
- Reset (async, rst_n=0): state=IDLE, starve_cnt=0; mem_read=mem_write=0, mem_addr=0, mem_wdata=0; i_ready=d_ready=0, grant_d=0. Any memory transaction in flight is abandoned.
- req_i = i_read|i_write; req_d = d_read|d_write.
- FSM states: IDLE, SERVE_I, SERVE_D, RELEASE.
- IDLE, with only req_d: grant D.
- IDLE, with only req_i: grant I.
- IDLE, with both: grant D if starve_cnt < STARVE_LIMIT, else grant I.
- On grant (same edge): register mem_addr and mem_wdata from the winner. Register mem_write = winner write. Register mem_read = winner read & ~winner write (write wins when both are asserted). Then go to SERVE_x.
- Strobes are visible the cycle after the request is first seen in IDLE.
- starve_cnt, updated only at grant edges:
  - D granted while req_i=1: increment, saturating at STARVE_LIMIT.
  - I granted: clear.
  - D granted with req_i=0: clear.
- SERVE_x:
  - Hold mem_* registers stable.
  - x_ready = mem_ready (combinational); the other ready stays 0.
  - On the mem_ready edge: clear mem_read and mem_write, go to RELEASE.
  - Stay in SERVE_x indefinitely while mem_ready=0.
- RELEASE: exactly one cycle, no grant, both readys 0, then go to IDLE. This lets the cache drop a request it registered off the ready edge, so the same request is not re-granted.
- i_rdata and d_rdata are wired directly to mem_rdata (broadcast). Only the ready outputs qualify the data.
- mem_ready seen in IDLE or RELEASE is ignored and produces no ready pulse.
- Requester withdraws its request while in SERVE_x: the memory transaction still completes and the ready still pulses.
- Requester changes addr or wdata while in SERVE_x: no effect, because the values were latched at grant.
- grant_d = (state==SERVE_D), registered.
- Throughput: per transaction, memory latency + 2 cycles (grant + release). Back-to-back requests alternate correctly through RELEASE.

Test Plan:
- Reset mid-transaction:
  - Stimulus: drive d_read, addr 0x0000010; deassert rst_n during SERVE_D.
  - Required: all mem_* and ready outputs go 0 immediately; after release, state is IDLE with no stale grant.
- Single I read:
  - Stimulus: i_read=1, i_addr=0x0000004; memory ready after 5 cycles with rdata 0xDEADBEEF_..._01.
  - Required: mem_read=1 with mem_addr=0x0000004 from cycle 1; i_ready pulses exactly 1 cycle with i_rdata equal to the memory line; d_ready stays 0.
- D write capture:
  - Stimulus: d_write=1, d_addr=0x0000020, d_wdata=0xA5 pattern.
  - Required: mem_write=1, mem_read=0, and mem_wdata equals the pattern, held until mem_ready; then one RELEASE cycle.
- Simultaneous requests:
  - Stimulus: I read 0x1 and D read 0x2 asserted in the same cycle.
  - Required: D is served first (grant_d=1); I is served next; total cycles = 2×(latency+2).
- Starvation guard (STARVE_LIMIT=4):
  - Stimulus: D requests continuously with i_read held.
  - Required: the 5th grant goes to I; the counter then clears and D resumes.
- Both strobes from one requester:
  - Stimulus: d_read=d_write=1.
  - Required: mem_write=1 and mem_read=0.
- Spurious ready:
  - Stimulus: mem_ready pulses while in IDLE.
  - Required: no i_ready or d_ready pulse.
